memory_control: RTL
===================

// Module: memory_control
// PURPOSE
// Memory-side responder for the cache bus that icache/dcache drive.
// Arbitrates I-cache fetches and D-cache reads/writes onto the single-ported RAM.
// Sequences each access until RAM reports ACCESS, then returns data and drops the wait line for one cycle.
// Sits between the caches block and the RAM model/bridge, one per core.
// PARAMETERS
// WORD_W     32    data/address width (matches word_t)
// WDOG_MAX   1023  cycles a grant may wait for ACCESS before wdog_err sets
// PORTS
// CLK       in   1       system clock
// nRST      in   1       async active-low reset
// iREN      in   1       icache fetch request
// iaddr     in   WORD_W  icache fetch address
// iwait     out  1       low only in the cycle the fetch completes
// iload     out  WORD_W  fetch data, valid when iwait low
// dREN      in   1       dcache read request
// dWEN      in   1       dcache write request
// daddr     in   WORD_W  dcache address
// dstore    in   WORD_W  dcache write data
// dwait     out  1       low only in the cycle the d-access completes
// dload     out  WORD_W  read data, valid when dwait low
// ramREN    out  1       RAM read strobe
// ramWEN    out  1       RAM write strobe
// ramaddr   out  WORD_W  RAM address
// ramstore  out  WORD_W  RAM write data
// ramload   in   WORD_W  RAM read data
// ramstate  in   2       ramstate_t: FREE, BUSY, ACCESS, ERROR
// wdog_err  out  1       sticky; a grant exceeded WDOG_MAX cycles
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low.
// - Reset values: state=IDLE, last_d=0, wdog count=0.
// - Reset outputs: iwait=dwait=1, ram*=0, iload=dload=0, wdog_err=0.
// - FSM states: IDLE, DGRANT, IGRANT.
// - IDLE, transitions:
//   - Only d pending -> DGRANT. Only iREN -> IGRANT.
//   - Both pending: go to IGRANT if last_d=1, else DGRANT (alternating, no starvation).
// - Latching on entry to a grant:
//   - addr, store, op are registered; op is write if dWEN, else read (dWEN wins over dREN).
//   - Set last_d=1 on DGRANT entry, last_d=0 on IGRANT entry.
// - In a grant:
//   - ram* driven from the latched regs; exactly one of ramREN/ramWEN high.
//   - Each cycle ramstate!=ACCESS: waits stay 1 and the wdog count increments.
//   - ramstate==ACCESS: the granted wait goes 0 combinationally that cycle.
//   - Same ACCESS cycle: iload/dload = ramload (reads); next state IDLE.
// - Latency: one registered IDLE->grant cycle plus RAM latency, minimum 2 cycles.
//   - Min 2 cycles = request seen in cycle 0, ACCESS in cycle 1.
//   - One IDLE bubble between back-to-back accesses.
// - Request dropped mid-grant (granted REN/WEN low): abort to IDLE next cycle.
//   - No wait pulse; ram strobes drop with the state.
// - Request changed mid-grant: ignored; latched values are used. Caches must hold until their wait is low.
// - ramstate ERROR: treated as BUSY and keeps waiting.
// - Watchdog:
//   - wdog_err sets when the count reaches WDOG_MAX; only reset clears it.
//   - The count saturates and clears on every grant entry.
// - The non-granted wait is always 1; iload/dload are 0 when not completing.
// - Async reset mid-grant: immediately IDLE, strobes low, no completion.
// STRUCTURE
// - cpu_types_pkg: word_t, ramstate_t (existing); add memctl_state_t {IDLE, DGRANT, IGRANT}.
// - Single module, no sub-modules; the arbiter is too small to split.
// TESTING
// - iREN=1, iaddr=0x40, RAM 2-cycle ACCESS, ramload=0xDEAD -> iwait low exactly once, in the ACCESS cycle.
//   - Same cycle: iload=0xDEAD; ramREN=1, ramaddr=0x40 throughout.
// - dWEN=1, daddr=0x80, dstore=0x1234 -> ramWEN=1, ramstore=0x1234, ramREN=0; dwait low on ACCESS; iwait stays 1.
// - iREN and dREN held for 4 accesses -> grants D,I,D,I; each completion separated by one IDLE cycle.
// - dREN dropped after 1 BUSY cycle -> IDLE next cycle, no dwait pulse; a pending iREN is granted after.
// - ramstate stuck BUSY for WDOG_MAX+5 cycles -> wdog_err=1 at cycle WDOG_MAX; stays 1 after ACCESS.
//   - wdog_err clears only on nRST.
// - nRST asserted mid-DGRANT -> strobes 0 and waits 1 immediately; after release, a fresh iREN is served.

Source files
------------

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Purpose  : Shared CPU bus types: machine word, RAM handshake state and the
//            memory-controller arbitration state.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // RAM handshake as reported by the RAM model/bridge
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Memory-controller arbitration state
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } memctl_state_t;

endpackage : cpu_types_pkg
`default_nettype wire

// File: rtl/memory_control_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_control_if
// Purpose  : Cache-side and RAM-side bus bundle around the memory controller.
//            'slave' is the controller view, 'master' the caches + RAM view.
// Revision : 1.0 - initial release
// ============================================================================
interface memory_control_if
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = 32
);

  // icache side
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;

  // dcache side
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;

  // RAM side
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface : memory_control_if
`default_nettype wire

// File: rtl/memory_control.sv
`default_nettype none
// ============================================================================
// Module   : memory_control
// Purpose  : Arbitrates icache fetches and dcache reads/writes onto a single
//            ported RAM. Requests are latched on grant entry; the granted wait
//            line drops for exactly the cycle RAM reports ACCESS. A sticky
//            watchdog flags any grant that waits WDOG_MAX cycles.
// Revision : 1.0 - initial release
// ============================================================================
module memory_control
  import cpu_types_pkg::*;
#(
  parameter int WORD_W   = 32,
  parameter int WDOG_MAX = 1023
) (
  input  logic                    CLK,
  input  logic                    nRST,
  memory_control_if.slave         bus,
  output logic                    wdog_err
);

  localparam int               CNT_W   = $clog2(WDOG_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WDOG_MAX);

  memctl_state_t     state_q, state_d;
  logic              last_d_q, last_d_d;   // 1 when the last grant went to dcache
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] store_q, store_d;
  logic              wr_q, wr_d;           // latched op: 1 = write
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              d_req;
  logic              granted_req;

  assign d_req    = bus.dREN | bus.dWEN;
  assign wdog_err = err_q;

  // State, latched request and watchdog registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Arbitration, RAM sequencing, completion and watchdog next-state
  always_comb begin
    state_d      = state_q;
    last_d_d     = last_d_q;
    addr_d       = addr_q;
    store_d      = store_q;
    wr_d         = wr_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    granted_req  = 1'b0;

    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;

    case (state_q)
      IDLE: begin
        // On a tie the side that did not win last time gets the grant
        if (d_req && (!bus.iREN || !last_d_q)) begin
          state_d  = DGRANT;
          addr_d   = bus.daddr;
          store_d  = bus.dstore;
          wr_d     = bus.dWEN;
          last_d_d = 1'b1;
          cnt_d    = '0;
        end else if (bus.iREN) begin
          state_d  = IGRANT;
          addr_d   = bus.iaddr;
          store_d  = '0;
          wr_d     = 1'b0;
          last_d_d = 1'b0;
          cnt_d    = '0;
        end
      end

      DGRANT, IGRANT: begin
        bus.ramREN   = ~wr_q;
        bus.ramWEN   = wr_q;
        bus.ramaddr  = addr_q;
        bus.ramstore = store_q;

        if (state_q == IGRANT) begin
          granted_req = bus.iREN;
        end else begin
          granted_req = wr_q ? bus.dWEN : bus.dREN;
        end

        // A withdrawn request aborts silently, even if RAM answers now
        if (!granted_req) begin
          state_d = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          state_d = IDLE;
          if (state_q == IGRANT) begin
            bus.iwait = 1'b0;
            bus.iload = bus.ramload;
          end else begin
            bus.dwait = 1'b0;
            if (!wr_q) begin
              bus.dload = bus.ramload;
            end
          end
        end else begin
          // BUSY, FREE and ERROR all keep waiting
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (cnt_d == CNT_MAX) begin
            err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule : memory_control
`default_nettype wire
